// File: rtl/ft_bridge_pkg.sv
// Shared types, constants and helpers for the FT synchronous FIFO bridge.
package ft_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRdTa,
    StRd,
    StRdEnd
  } ft_state_e;

  localparam int unsigned SkidDepth = 2;

  function automatic logic [31:0] sat_inc32(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/ft_skid_buf.sv
// Two-entry in-order skid FIFO holding RX words (data plus byte enables) captured from the FT bus.
module ft_skid_buf
  import ft_bridge_pkg::*;
#(
  parameter int unsigned Width = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem_q [SkidDepth];
  logic             wptr_q, wptr_d;
  logic             rptr_q, rptr_d;
  logic [1:0]       cnt_q, cnt_d;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_i) wptr_d = ~wptr_q;
    if (pop_i)  rptr_d = ~rptr_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by cnt_q alone.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/ft_sync_bridge.sv
// Bridge between an FT synchronous-FIFO device and local TX/RX FIFOs, round-robin burst arbitration.
// Optional word counters are built when FT_BRIDGE_STATS_EN is defined.
module ft_sync_bridge
  import ft_bridge_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 64
) (
  input  logic                ft_clkout,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   ft_data_i,
  output logic [DATA_W-1:0]   ft_data_o,
  output logic                ft_data_oe,
  input  logic [DATA_W/8-1:0] ft_be_i,
  output logic [DATA_W/8-1:0] ft_be_o,
  input  logic                ft_rxf_n,
  input  logic                ft_txe_n,
  output logic                ft_rd_n,
  output logic                ft_wr_n,
  output logic                ft_oe_n,
  output logic                ft_siwu_n,
  input  logic [DATA_W-1:0]   tx_rdata,
  input  logic                tx_rempty,
  output logic                tx_rinc,
  output logic [DATA_W-1:0]   rx_wdata,
  output logic [DATA_W/8-1:0] rx_wbe,
  input  logic                rx_wfull,
  output logic                rx_winc,
  input  logic                tx_flush,
  output logic [31:0]         stat_tx_words,
  output logic [31:0]         stat_rx_words
);

  localparam int unsigned BeW       = DATA_W / 8;
  localparam int unsigned CntW      = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] BurstLast = CntW'(MAX_BURST - 1);
  localparam logic [1:0]      SkidFull  = 2'(SkidDepth);

  ft_state_e         state_q, state_d;
  logic              prio_wr_q, prio_wr_d;
  logic              flush_q, flush_d;
  logic [CntW-1:0]   burst_q, burst_d;
  logic [1:0]        skid_cnt;
  logic [DATA_W+BeW-1:0] skid_rdata;
  logic              skid_empty, skid_push, skid_pop, rd_en;
  logic              wr_elig, rd_elig, burst_end, siwu_fire;

  assign ft_data_o  = tx_rdata;
  assign ft_be_o    = '1;
  assign skid_empty = (skid_cnt == 2'd0);
  assign wr_elig    = ~ft_txe_n & ~tx_rempty;
  assign rd_elig    = ~ft_rxf_n & skid_empty;
  assign rd_en      = (state_q == StRd) && (skid_cnt < SkidFull);
  assign skid_push  = rd_en & ~ft_rxf_n;
  // Drain runs regardless of FSM state so RD_END/IDLE never strand words.
  assign skid_pop   = ~skid_empty & ~rx_wfull;
  assign rx_winc    = skid_pop;
  assign rx_wdata   = skid_rdata[DATA_W-1:0];
  assign rx_wbe     = skid_rdata[DATA_W+:BeW];
  assign ft_siwu_n  = ~siwu_fire;
  assign flush_d    = tx_flush | (flush_q & ~siwu_fire);

  always_comb begin
    state_d    = state_q;
    prio_wr_d  = prio_wr_q;
    burst_d    = burst_q;
    burst_end  = 1'b0;
    siwu_fire  = 1'b0;
    ft_wr_n    = 1'b1;
    ft_rd_n    = 1'b1;
    ft_oe_n    = 1'b1;
    ft_data_oe = 1'b0;
    tx_rinc    = 1'b0;
    unique case (state_q)
      StIdle: begin
        siwu_fire = flush_q & tx_rempty;
        burst_d   = '0;
        if (wr_elig && (prio_wr_q || !rd_elig)) begin
          state_d = StWr;
        end else if (rd_elig) begin
          state_d = StRdTa;
        end
      end
      StWr: begin
        ft_data_oe = 1'b1;
        ft_wr_n    = tx_rempty;
        tx_rinc    = ~tx_rempty & ~ft_txe_n;
        if (tx_rinc) burst_d = burst_q + CntW'(1);
        if (ft_txe_n || tx_rempty || (tx_rinc && (burst_q == BurstLast))) begin
          state_d   = StIdle;
          burst_end = 1'b1;
        end
      end
      StRdTa: begin
        ft_oe_n = 1'b0;
        state_d = StRd;
      end
      StRd: begin
        ft_oe_n = 1'b0;
        ft_rd_n = ~rd_en;
        if (skid_push) burst_d = burst_q + CntW'(1);
        if (ft_rxf_n || (skid_push && (burst_q == BurstLast))) begin
          state_d   = StRdEnd;
          burst_end = 1'b1;
        end
      end
      StRdEnd: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (burst_end) prio_wr_d = ~prio_wr_q;
  end

  always_ff @(posedge ft_clkout or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      prio_wr_q <= 1'b1;
      flush_q   <= 1'b0;
      burst_q   <= '0;
    end else begin
      state_q   <= state_d;
      prio_wr_q <= prio_wr_d;
      flush_q   <= flush_d;
      burst_q   <= burst_d;
    end
  end

  ft_skid_buf #(
    .Width (DATA_W + BeW)
  ) u_skid (
    .clk_i   (ft_clkout),
    .rst_ni  (rst_n),
    .push_i  (skid_push),
    .wdata_i ({ft_be_i, ft_data_i}),
    .pop_i   (skid_pop),
    .rdata_o (skid_rdata),
    .count_o (skid_cnt)
  );

`ifdef FT_BRIDGE_STATS_EN
  logic [31:0] stat_tx_q, stat_tx_d, stat_rx_q, stat_rx_d;

  always_comb begin
    stat_tx_d = tx_rinc ? sat_inc32(stat_tx_q) : stat_tx_q;
    stat_rx_d = rx_winc ? sat_inc32(stat_rx_q) : stat_rx_q;
  end

  always_ff @(posedge ft_clkout or negedge rst_n) begin
    if (!rst_n) begin
      stat_tx_q <= '0;
      stat_rx_q <= '0;
    end else begin
      stat_tx_q <= stat_tx_d;
      stat_rx_q <= stat_rx_d;
    end
  end

  assign stat_tx_words = stat_tx_q;
  assign stat_rx_words = stat_rx_q;
`else
  assign stat_tx_words = '0;
  assign stat_rx_words = '0;
`endif

endmodule

// File: doc/ft_sync_bridge.md
FT_SYNC_BRIDGE -- requirements
Module: ft_sync_bridge

Interface
REQ-001 Parameter DATA_W, default 8, FT data bus width; legal values are 8, 16 and 32.
REQ-002 Parameter MAX_BURST, default 64, maximum words per burst before re-arbitration; legal range is 1..1023.
REQ-003 ft_clkout  in  1  sole clock, supplied by the FT device; one clock, with asynchronous active-low reset rst_n.
REQ-004 rst_n  in  1  async active-low reset.
REQ-005 ft_data_i / ft_data_o / ft_data_oe  in/out/out  DATA_W/DATA_W/1  split tristate bus; pads live at top level.
REQ-006 ft_be_i / ft_be_o  in/out  DATA_W/8 each  byte enables; ft_be_o is all-ones, ft_be_i is captured with read data.
REQ-007 ft_rxf_n, ft_txe_n  in  1  FT has-data and FT has-space flags, both active-low.
REQ-008 ft_rd_n, ft_wr_n, ft_oe_n, ft_siwu_n  out  1  FT strobes, all active-low.
REQ-009 tx_rdata / tx_rempty / tx_rinc  in/in/out  DATA_W/1/1  first-word-fall-through TX FIFO read side.
REQ-010 rx_wdata / rx_wbe / rx_wfull / rx_winc  out/out/in/out  DATA_W/DATA_W/8/1/1  RX FIFO write side.
REQ-011 tx_flush  in  1  send-immediate request pulse.
REQ-012 stat_tx_words, stat_rx_words  out  32  accepted-word counters.

Function
REQ-013 FSM states: IDLE, WR, RD_TA, RD, RD_END.
- The state register, skid storage and counters are registered on rising ft_clkout.
- Strobes and ft_data_oe are decoded from registered state only, plus the combinational terms named below.
REQ-014 IDLE arbitration:
- Write is eligible when ft_txe_n=0 and tx_rempty=0.
- Read is eligible when ft_rxf_n=0 and the skid buffer is empty.
- If both are eligible, a priority bit decides; the priority bit toggles at the end of every burst (round-robin).
REQ-015 WR state:
- ft_data_oe=1 and ft_data_o=tx_rdata.
- ft_wr_n=tx_rempty.
- tx_rinc=~tx_rempty & ~ft_txe_n.
- A word is accepted only on an edge where tx_rinc=1; no word is lost or duplicated when ft_txe_n rises mid-burst.
REQ-016 WR exits to IDLE on the first edge where any of the following holds: ft_txe_n=1, tx_rempty=1, or the accepted-word count reaches MAX_BURST.
REQ-017 RD_TA lasts one cycle:
- ft_oe_n=0, ft_rd_n=1, ft_data_oe=0 (bus turnaround).
- Always proceeds to RD.
REQ-018 RD state:
- ft_oe_n=0.
- ft_rd_n=0 only while skid count < 2.
- A word, together with ft_be_i, is captured into the skid buffer on each edge where ft_rd_n=0 and ft_rxf_n=0.
REQ-019 Skid buffer drain:
- The 2-entry skid buffer drains in order: rx_winc = skid_nonempty & ~rx_wfull.
- rx_wdata and rx_wbe present the head entry.
- A simultaneous capture and drain keeps the count unchanged.
REQ-020 RD exits to RD_END on either of these edges:
- ft_rxf_n=1 is sampled.
- The captured-word count reaches MAX_BURST.
REQ-021 RD_END lasts one cycle with ft_oe_n=1 and ft_data_oe=0, then returns to IDLE. The skid buffer keeps draining independently of the FSM state.
REQ-022 Burst counter: width clog2(MAX_BURST+1); cleared on every IDLE exit.
REQ-023 ft_data_oe=1 never coincides with ft_oe_n=0, in any state or cycle.
REQ-024 tx_flush is latched into a pending flag. ft_siwu_n is driven low for exactly one cycle when all of the following hold:
- the FSM is in IDLE;
- the flag is pending;
- tx_rempty=1.
The flag clears in that same cycle.
REQ-025 ft_siwu_n and ft_wr_n are never low in the same cycle.

Reset
REQ-026 Assertion of rst_n=0 takes effect asynchronously:
- state=IDLE;
- ft_rd_n, ft_wr_n, ft_oe_n and ft_siwu_n = 1;
- ft_data_oe=0, tx_rinc=0, rx_winc=0;
- skid buffer emptied, priority set to write, flush flag cleared.
REQ-027 Reset asserted mid-burst discards skid contents. Deassertion is synchronised to ft_clkout by the top level.

Configuration
REQ-028 Macro FT_BRIDGE_STATS_EN:
- Defined: stat_tx_words counts edges with tx_rinc=1, and stat_rx_words counts edges with rx_winc=1.
- Both counters saturate at 2^32-1 and reset to 0.
- Undefined: both outputs are constant 0 and no counter flops exist.

Structure
REQ-029 Package ft_bridge_pkg holds:
- the state enum;
- the skid depth constant (2);
- the saturating-increment function.
REQ-030 Sub-module ft_skid_buf, a 2-entry FIFO with count output, holds the RX skid storage. The FSM stays in ft_sync_bridge.

Verification
REQ-031 DATA_W=16, TX holds 5 words, ft_txe_n=0 throughout -> 5 WR cycles, tx_rinc high for 5 cycles, stat_tx_words=5, return to IDLE.
REQ-032 DATA_W=8, TX holds 10 words, ft_txe_n rises after word 3 for 4 cycles -> bytes 1..10 are written exactly once and in order, and tx_rinc=0 while ft_txe_n=1.
REQ-033 MAX_BURST=4, TX and RX both continuously eligible -> bursts alternate W4, R4, W4, with RD_TA and RD_END each one cycle and ft_data_oe=0 during both.
REQ-034 RD burst of 8 words with rx_wfull held 1 from word 2 for 6 cycles -> ft_rd_n deasserts once the skid buffer holds 2 entries, all 8 words later arrive in order, and nothing is dropped.
REQ-035 rst_n pulled low during an RD burst with the skid buffer holding 1 entry -> all strobes go high immediately, ft_data_oe=0, and after release the FSM is in IDLE with rx_winc=0.
REQ-036 tx_flush pulsed while WR is draining 3 words -> ft_siwu_n goes low for exactly 1 cycle after tx_rempty=1 in IDLE, never overlapping ft_wr_n=0.
